// File: rtl/uart_tx_pkg.sv
// Shared UART TX definitions: the line-mux select codes, the frame sequencer states
// and the parity-type encoding. The select codes must match the existing output mux.
package uart_tx_pkg;

  localparam logic [1:0] START_SEL = 2'b00;
  localparam logic [1:0] STOP_SEL  = 2'b01;
  localparam logic [1:0] DATA_SEL  = 2'b10;
  localparam logic [1:0] PAR_SEL   = 2'b11;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // IDLE and STOP share the line-high select code.
  function automatic logic [1:0] sel_for_state(input tx_state_t s);
    logic [1:0] sel;
    sel = STOP_SEL;
    case (s)
      START:   sel = START_SEL;
      DATA:    sel = DATA_SEL;
      PARITY:  sel = PAR_SEL;
      default: sel = STOP_SEL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_parity_calc.sv
// Combinational parity over a DATA_WIDTH word, even or odd; shared with the RX checker.
// Zero latency, no flow control.
module uart_tx_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  always_comb begin
    par_bit = 1'b0;
    case (par_typ)
      EVEN:    par_bit = ^data;
      ODD:     par_bit = ~(^data);
      default: par_bit = 1'b0;
    endcase
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_WIDTH data bits LSB first, optional parity, stop; one bit per bit_tick.
// Outputs registered; busy is the only upstream backpressure, Data_Valid is ignored while it is high.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  bit_tick,
  output logic [1:0]            MUX_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_nxt;
  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_bit_q, par_bit_nxt;
  logic                  ser_data_q, ser_data_nxt;
  logic                  busy_q;
  logic [1:0]            mux_sel_q;
  logic                  par_calc;

  uart_tx_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  always_comb begin
    state_nxt    = state_q;
    shift_nxt    = shift_q;
    bit_cnt_nxt  = bit_cnt_q;
    par_en_nxt   = par_en_q;
    par_bit_nxt  = par_bit_q;
    ser_data_nxt = ser_data_q;

    case (state_q)
      IDLE: begin
        // bit_tick is deliberately not looked at here, so an acceptance-cycle tick never shortens START.
        if (Data_Valid) begin
          state_nxt   = START;
          shift_nxt   = P_DATA;
          par_en_nxt  = PAR_EN;
          par_bit_nxt = par_calc;
        end
      end
      START: begin
        if (bit_tick) begin
          state_nxt    = DATA;
          bit_cnt_nxt  = '0;
          ser_data_nxt = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            state_nxt = par_en_q ? PARITY : STOP;
          end else begin
            shift_nxt    = shift_q >> 1;
            bit_cnt_nxt  = bit_cnt_q + CNT_W'(1);
            ser_data_nxt = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_tick) state_nxt = STOP;
      end
      STOP: begin
        if (bit_tick) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy and MUX_sel are registered from the next state so they line up with it cycle for cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      ser_data_q <= 1'b0;
      busy_q     <= 1'b0;
      mux_sel_q  <= STOP_SEL;
    end else begin
      state_q    <= state_nxt;
      shift_q    <= shift_nxt;
      bit_cnt_q  <= bit_cnt_nxt;
      par_en_q   <= par_en_nxt;
      par_bit_q  <= par_bit_nxt;
      ser_data_q <= ser_data_nxt;
      busy_q     <= (state_nxt != IDLE);
      mux_sel_q  <= sel_for_state(state_nxt);
    end
  end

  assign MUX_sel  = mux_sel_q;
  assign ser_data = ser_data_q;
  assign par_bit  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-position reference model compared every cycle, plus directed literal frames.
module tb_uart_tx_ctrl;

  localparam int W = 8;

  logic         CLK;
  logic         RST;
  logic [W-1:0] P_DATA;
  logic         Data_Valid;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         bit_tick;
  logic [1:0]   MUX_sel;
  logic         ser_data;
  logic         par_bit;
  logic         busy;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .bit_tick   (bit_tick),
    .MUX_sel    (MUX_sel),
    .ser_data   (ser_data),
    .par_bit    (par_bit),
    .busy       (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a list of tick-delimited positions
  // 0 = start, 1..W = data bit pos-1, W+1 = parity (if enabled), last = stop.
  bit         m_active = 1'b0;
  int         m_pos = 0;
  logic [W-1:0] m_data = '0;
  bit         m_pen = 1'b0;
  bit         m_pbit = 1'b0;
  bit         m_ser = 1'b0;

  function automatic bit parity_of(input logic [W-1:0] d, input logic typ);
    int ones;
    ones = 0;
    for (int i = 0; i < W; i++) ones += int'(d[i]);
    // Even parity bit makes the total count of ones even; odd makes it odd.
    return typ ? ((ones % 2) == 0) : ((ones % 2) == 1);
  endfunction

  function automatic logic [1:0] exp_sel();
    if (!m_active)                       return 2'b01;
    if (m_pos == 0)                      return 2'b00;
    if (m_pos <= W)                      return 2'b10;
    if (m_pos == W + 1 && m_pen)         return 2'b11;
    return 2'b01;
  endfunction

  initial forever begin
    @(posedge CLK);
    if (RST) begin
      m_active = 1'b0;
      m_pos    = 0;
      m_pbit   = 1'b0;
      m_ser    = 1'b0;
    end else if (!m_active) begin
      if (Data_Valid) begin
        m_active = 1'b1;
        m_pos    = 0;
        m_data   = P_DATA;
        m_pen    = PAR_EN;
        m_pbit   = parity_of(P_DATA, PAR_TYP);
      end
    end else if (bit_tick) begin
      m_pos++;
      if (m_pos >= 1 && m_pos <= W) m_ser = m_data[m_pos-1];
      if (m_pos == 2 + W + int'(m_pen)) m_active = 1'b0;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (chk_en) begin
      chk("cyc_mux_sel", 32'(MUX_sel), 32'(exp_sel()));
      chk("cyc_busy", 32'(busy), 32'(m_active));
      chk("cyc_ser_data", 32'(ser_data), 32'(m_ser));
      chk("cyc_par_bit", 32'(par_bit), 32'(m_pbit));
    end
  end

  // Per-tick observations of one directed frame.
  logic [1:0] obs_sel [0:19];
  logic       obs_ser [0:19];
  logic [1:0] start_sel;
  logic       start_par;
  int         nticks;
  int         busy_cyc;

  task automatic run_frame(input logic [W-1:0] d, input logic pen, input logic ptyp,
                           input int period, input int dv_at_tick);
    bit done;
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1; bit_tick = 1'b0;
    @(negedge CLK);
    Data_Valid = 1'b0;
    start_sel = MUX_sel;
    start_par = par_bit;
    busy_cyc = 0;
    nticks = 0;
    done = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      for (int c = 0; c < period; c++) begin
        if (busy) busy_cyc++;
        bit_tick = (c == period - 1);
        if (t == dv_at_tick && c == 0) begin
          Data_Valid = 1'b1; P_DATA = 8'hFF; PAR_EN = ~pen; PAR_TYP = ~ptyp;
        end else begin
          Data_Valid = 1'b0;
        end
        @(negedge CLK);
      end
      bit_tick = 1'b0;
      obs_sel[t] = MUX_sel;
      obs_ser[t] = ser_data;
      nticks++;
      if (!busy) done = 1'b1;
    end
    if (!done) chk("frame_end_timeout", 32'(busy), 32'd0);
  endtask

  task automatic check_bits(input string name, input logic [W-1:0] bits);
    for (int i = 0; i < W; i++) chk(name, 32'(obs_ser[i]), 32'(bits[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, time %0t required under 2000000", $time);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] sel_a5 [0:10];
    logic [W-1:0] exp_bits;
    int n11;
    int idle_busy;

    RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; bit_tick = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    chk_en = 1'b1;
    chk("rst_mux_sel", 32'(MUX_sel), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ser_data", 32'(ser_data), 32'h0);
    chk("rst_par_bit", 32'(par_bit), 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_mux_sel", 32'(MUX_sel), 32'h1);
      chk("idle_busy", 32'(busy), 32'h0);
    end

    // Even parity, 0xA5.
    sel_a5 = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01};
    run_frame(8'hA5, 1'b1, 1'b0, 4, -1);
    chk("a5_start_sel", 32'(start_sel), 32'h0);
    chk("a5_model_par", 32'(m_pbit), 32'h0);
    chk("a5_par_bit", 32'(start_par), 32'h0);
    for (int i = 0; i < 11; i++) chk("a5_sel_seq", 32'(obs_sel[i]), 32'(sel_a5[i]));
    exp_bits = 8'hA5;
    check_bits("a5_ser_bits", exp_bits);
    chk("a5_ticks", 32'(nticks), 32'd11);
    chk("a5_busy_cycles", 32'(busy_cyc), 32'd44);

    // No parity, odd type must not matter.
    run_frame(8'h01, 1'b0, 1'b1, 3, -1);
    chk("np_sel_after_data", 32'(obs_sel[8]), 32'h1);
    n11 = 0;
    for (int i = 0; i < nticks; i++) if (obs_sel[i] == 2'b11) n11++;
    chk("np_no_parity_sel", 32'(n11), 32'd0);
    chk("np_ticks", 32'(nticks), 32'd10);
    exp_bits = 8'h01;
    check_bits("np_ser_bits", exp_bits);

    // Odd parity.
    run_frame(8'h07, 1'b1, 1'b1, 2, -1);
    chk("odd_07_par_bit", 32'(start_par), 32'h0);
    chk("odd_07_ticks", 32'(nticks), 32'd11);
    run_frame(8'h03, 1'b1, 1'b1, 2, -1);
    chk("odd_03_par_bit", 32'(start_par), 32'h1);
    chk("odd_03_model_par", 32'(m_pbit), 32'h1);

    // Data_Valid mid-DATA must be ignored.
    run_frame(8'h3C, 1'b1, 1'b0, 4, 3);
    exp_bits = 8'h3C;
    check_bits("dv_mid_ser_bits", exp_bits);
    chk("dv_mid_ticks", 32'(nticks), 32'd11);
    idle_busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (busy) idle_busy++;
    end
    chk("dv_mid_no_second_frame", 32'(idle_busy), 32'd0);
    chk("dv_mid_par_kept", 32'(par_bit), 32'h0);

    // Reset during DATA bit 3.
    @(negedge CLK);
    P_DATA = 8'h5A; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    for (int t = 0; t < 4; t++) begin
      bit_tick = 1'b0;
      @(negedge CLK);
      bit_tick = 1'b1;
      @(negedge CLK);
    end
    bit_tick = 1'b0;
    chk("rstmid_in_data", 32'(MUX_sel), 32'h2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rstmid_mux_sel", 32'(MUX_sel), 32'h1);
    chk("rstmid_busy", 32'(busy), 32'h0);
    chk("rstmid_par_bit", 32'(par_bit), 32'h0);
    run_frame(8'hC3, 1'b0, 1'b0, 3, -1);
    exp_bits = 8'hC3;
    check_bits("rstmid_next_bits", exp_bits);
    chk("rstmid_next_ticks", 32'(nticks), 32'd10);
    chk("rstmid_next_start", 32'(start_sel), 32'h0);

    // Randomized traffic: ticks, requests, config and occasional reset.
    for (int i = 0; i < 4000; i++) begin
      @(negedge CLK);
      RST        = ($urandom_range(0, 299) == 0);
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = W'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      bit_tick   = ($urandom_range(0, 2) == 0);
    end
    @(negedge CLK);
    RST = 1'b0; Data_Valid = 1'b0; bit_tick = 1'b0;
    repeat (3) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmitter. It accepts a parallel byte on a valid strobe and latches it with its parity configuration. It then steps through start, data (LSB first), optional parity and stop bits, one bit per baud tick. It drives the output mux select code plus the serial data and parity bits the mux consumes, and signals busy to the upstream producer.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (valid range 5..9)

Ports:
CLK  input  1  system clock; all state changes on rising edge
RST  input  1  synchronous reset, active-high
P_DATA  input  DATA_WIDTH  parallel data to transmit
Data_Valid  input  1  request strobe; sampled only in IDLE
PAR_EN  input  1  1 = insert parity bit; latched at acceptance
PAR_TYP  input  1  0 = even, 1 = odd; latched at acceptance
bit_tick  input  1  one-cycle baud enable; marks end of current bit period
MUX_sel  output  2  line select: 00 start, 01 stop/idle, 10 data, 11 parity
ser_data  output  1  current data bit for the mux
par_bit  output  1  computed parity bit for the mux
busy  output  1  frame in progress

Behaviour:
- Clocking and reset: one clock (CLK). Reset is synchronous and active-high (RST). All outputs are registered.
- Reset values: state=IDLE, MUX_sel=01, ser_data=0, par_bit=0, busy=0, bit_cnt=0, shift register=0.
- RST asserted mid-frame: the frame is aborted. The line returns to 01 on the cycle after the reset edge. No partial completion.
- States: IDLE, START, DATA, PARITY, STOP.
- MUX_sel per state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
- IDLE, Data_Valid=1: latch P_DATA into the shift register and latch PAR_EN/PAR_TYP. Compute par_bit = ^P_DATA ^ PAR_TYP. Next state START; busy=1 from the next cycle.
- Data_Valid while not IDLE: ignored. Latched data and configuration are unaffected.
- Bit timing: each non-IDLE state holds until a cycle with bit_tick=1, and advances on that edge. A bit_tick in the acceptance cycle does not count toward START.
- START + tick: go to DATA, bit_cnt=0, ser_data=shift[0].
- DATA + tick, bit_cnt < DATA_WIDTH-1: shift right, bit_cnt+1, ser_data = next LSB.
- DATA + tick, bit_cnt = DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
- PARITY + tick: go to STOP.
- STOP + tick: go to IDLE; busy=0 from the next cycle.
- Minimum gap: one IDLE cycle between frames, since acceptance happens only in IDLE.
- bit_cnt width: $clog2(DATA_WIDTH); it never wraps past DATA_WIDTH-1.
- par_bit is held stable from acceptance until the next acceptance.
- Frame length: 1 + DATA_WIDTH + PAR_EN + 1 ticks.

Decomposition:
- Shared package uart_tx_pkg holds:
  - MUX_sel encodings START_SEL=2'b00, STOP_SEL=2'b01, DATA_SEL=2'b10, PAR_SEL=2'b11, identical to the existing output mux;
  - state enum;
  - the parity-type constants EVEN=0, ODD=1.
- One sub-module: uart_tx_parity_calc. It is combinational parity over DATA_WIDTH with PAR_TYP, and is reused by the RX checker.
- FSM, bit counter and shift register stay in uart_tx_ctrl.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, release. Required: MUX_sel=01, busy=0, ser_data=0, par_bit=0; Data_Valid=0 keeps this for 20 cycles.
- Even parity frame: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, bit_tick every 4 cycles. Required:
  - MUX_sel sequence 00, then 10 ×8, then 11, then 01;
  - ser_data=1,0,1,0,0,1,0,1;
  - par_bit=0;
  - busy high for exactly 11 tick periods.
- No parity, odd config ignored: P_DATA=8'h01, PAR_EN=0, PAR_TYP=1. Required: MUX_sel goes 10→01 directly after the 8th data tick; MUX_sel never shows 11; 10 ticks per frame.
- Odd parity: P_DATA=8'h07, PAR_EN=1, PAR_TYP=1. Required: par_bit=0. Then P_DATA=8'h03 gives par_bit=1.
- Data_Valid during frame: pulse Data_Valid with P_DATA=8'hFF mid-DATA of a frame carrying 8'h3C. Required: transmitted bits remain 0,0,1,1,1,1,0,0; no second frame starts.
- Reset mid-frame: assert RST during DATA bit 3. Required: next cycle MUX_sel=01, busy=0; a new Data_Valid afterwards produces a full clean frame.
